// File: rtl/cmos_capture_ctrl.sv
// DVP camera capture front-end: beat assembly, start-up frame skip, geometry checking.
// Optional build macro CMOS_CAP_TESTPAT_EN replaces sensor pixels with an x/y/frame pattern.
module cmos_capture_ctrl #(
  parameter int unsigned H_DISP        = 1280,
  parameter int unsigned V_DISP        = 720,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BEATS_PER_PIX = 2,
  parameter int unsigned PIX_FMT       = 0,
  parameter int unsigned SKIP_FRAMES   = 10
) (
  input  logic              cmos_pclk,
  input  logic              rst,
  input  logic              cmos_vsync,
  input  logic              cmos_href,
  input  logic [DATA_W-1:0] cmos_data,
  input  logic              cmos_cfg_done,
  input  logic              cap_en,
  output logic [23:0]       cmos_frame_data,
  output logic              cmos_frame_valid,
  output logic              cmos_frame_sop,
  output logic              cmos_frame_eop,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned XW    = $clog2(H_DISP + 1);
  localparam int unsigned YW    = $clog2(V_DISP + 1);
  localparam int unsigned SW    = $clog2(SKIP_FRAMES + 2);
  localparam int unsigned PIX_W = DATA_W * BEATS_PER_PIX;

  localparam logic [XW-1:0] XMax     = XW'(H_DISP);
  localparam logic [XW-1:0] XLast    = XW'(H_DISP - 1);
  localparam logic [YW-1:0] YMax     = YW'(V_DISP);
  localparam logic [YW-1:0] YLast    = YW'(V_DISP - 1);
  localparam logic [SW-1:0] SkipLast = SW'(SKIP_FRAMES - 1);

  typedef enum logic [1:0] {StWaitCfg, StSkip, StWaitVs, StCapture} state_e;

  state_e state_q, state_d;

  logic              vs_q, vs_prev_q, href_q, href_prev_q, cfg_q, en_q;
  logic [DATA_W-1:0] data_q, hi_q;
  logic [SW-1:0]     skip_cnt_q;
  logic [XW-1:0]     x_cnt_q, x_cnt_d;
  logic [YW-1:0]     y_cnt_q, y_cnt_d;
  logic              x_over_q, x_over_d, y_over_q, y_over_d;
  logic              beat_q, beat_d, eop_seen_q, eop_seen_d;
  logic              valid_q, sop_q, eop_q, err_q;
  logic [23:0]       data_out_q;
  logic [15:0]       frame_cnt_q;

  logic vs_fall, vs_rise, href_fall;
  logic skip_inc, frame_start, frame_end, restart_err;
  logic beat_act, pix_done, emit, sop_hit, eop_hit, line_err, end_err;
  logic [PIX_W-1:0] pix_word;
  logic [15:0]      pix16;
  logic [23:0]      pix_out;

  assign vs_fall   = vs_prev_q & ~vs_q;
  assign vs_rise   = ~vs_prev_q & vs_q;
  assign href_fall = href_prev_q & ~href_q;

  always_comb begin
    state_d     = state_q;
    skip_inc    = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    restart_err = 1'b0;
    unique case (state_q)
      StWaitCfg: if (cfg_q) state_d = (SKIP_FRAMES == 0) ? StWaitVs : StSkip;
      StSkip: begin
        if (vs_fall) begin
          if (skip_cnt_q == SkipLast) state_d = StWaitVs;
          else                        skip_inc = 1'b1;
        end
      end
      StWaitVs: begin
        if (vs_fall && en_q) begin
          state_d     = StCapture;
          frame_start = 1'b1;
        end
      end
      StCapture: begin
        if (vs_rise) begin
          state_d   = StWaitVs;
          frame_end = 1'b1;
        end else if (vs_fall) begin
          // vsync fell without rising: abandon the frame and start over
          frame_start = 1'b1;
          restart_err = 1'b1;
        end
      end
      default: state_d = StWaitCfg;
    endcase
  end

  always_comb begin
    beat_act = (state_q == StCapture) && href_q;
    pix_done = beat_act && ((BEATS_PER_PIX == 1) || beat_q);
    if (BEATS_PER_PIX == 1) pix_word = PIX_W'(data_q);
    else                    pix_word = PIX_W'({hi_q, data_q});
    emit    = pix_done && (x_cnt_q < XMax) && (y_cnt_q < YMax);
    sop_hit = emit && (x_cnt_q == '0) && (y_cnt_q == '0);
    eop_hit = emit && (x_cnt_q == XLast) && (y_cnt_q == YLast);

    x_cnt_d    = x_cnt_q;
    x_over_d   = x_over_q;
    y_cnt_d    = y_cnt_q;
    y_over_d   = y_over_q;
    beat_d     = beat_q;
    eop_seen_d = eop_seen_q | eop_hit;
    line_err   = 1'b0;
    if (pix_done) begin
      if (x_cnt_q == XMax) x_over_d = 1'b1;
      else                 x_cnt_d  = x_cnt_q + 1'b1;
    end
    if (beat_act) beat_d = (BEATS_PER_PIX == 2) && !beat_q;
    if (href_fall) begin
      beat_d   = 1'b0;
      x_cnt_d  = '0;
      x_over_d = 1'b0;
      if (state_q == StCapture) begin
        line_err = (x_cnt_q != XMax) || x_over_q;
        if (y_cnt_q == YMax) y_over_d = 1'b1;
        else                 y_cnt_d  = y_cnt_q + 1'b1;
      end
    end
    // Line count includes an href_fall landing in the same cycle as vs_rise
    end_err = frame_end && ((y_cnt_d != YMax) || y_over_d);
    if (frame_start) begin
      x_cnt_d    = '0;
      x_over_d   = 1'b0;
      y_cnt_d    = '0;
      y_over_d   = 1'b0;
      beat_d     = 1'b0;
      eop_seen_d = 1'b0;
    end
  end

  always_comb begin
    pix16 = 16'(pix_word);
`ifdef CMOS_CAP_TESTPAT_EN
    pix_out = {8'(x_cnt_q), 8'(y_cnt_q), frame_cnt_q[7:0]};
`else
    if (PIX_FMT == 0) pix_out = {pix16[15:11], 3'b000, pix16[10:5], 2'b00, pix16[4:0], 3'b000};
    else              pix_out = 24'(pix_word);
`endif
  end

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      state_q     <= StWaitCfg;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      cfg_q       <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
      hi_q        <= '0;
      skip_cnt_q  <= '0;
      x_cnt_q     <= '0;
      x_over_q    <= 1'b0;
      y_cnt_q     <= '0;
      y_over_q    <= 1'b0;
      beat_q      <= 1'b0;
      eop_seen_q  <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= cmos_vsync;
      vs_prev_q   <= vs_q;
      href_q      <= cmos_href;
      href_prev_q <= href_q;
      cfg_q       <= cmos_cfg_done;
      en_q        <= cap_en;
      data_q      <= cmos_data;
      if (beat_act && !beat_q) hi_q <= data_q;
      if (skip_inc) skip_cnt_q <= skip_cnt_q + 1'b1;
      x_cnt_q     <= x_cnt_d;
      x_over_q    <= x_over_d;
      y_cnt_q     <= y_cnt_d;
      y_over_q    <= y_over_d;
      beat_q      <= beat_d;
      eop_seen_q  <= eop_seen_d;
      valid_q     <= emit;
      sop_q       <= sop_hit;
      eop_q       <= eop_hit;
      err_q       <= line_err | end_err | restart_err;
      if (emit) data_out_q <= pix_out;
      if (frame_end && (eop_seen_q || eop_hit)) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign cmos_frame_data  = data_out_q;
  assign cmos_frame_valid = valid_q;
  assign cmos_frame_sop   = sop_q;
  assign cmos_frame_eop   = eop_q;
  assign frame_err        = err_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Scoreboard bench for cmos_capture_ctrl: 8x4 frames, 2 skipped frames, RGB565 input.
module tb_cmos_capture_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst, vsync, href, cfg_done, cap_en;
  logic [7:0]  data;
  logic [23:0] frame_data;
  logic        frame_valid, frame_sop, frame_eop, frame_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  cmos_capture_ctrl #(
    .H_DISP(H), .V_DISP(V), .DATA_W(8), .BEATS_PER_PIX(2), .PIX_FMT(0), .SKIP_FRAMES(2)
  ) dut (
    .cmos_pclk(clk), .rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
    .cmos_cfg_done(cfg_done), .cap_en(cap_en), .cmos_frame_data(frame_data),
    .cmos_frame_valid(frame_valid), .cmos_frame_sop(frame_sop), .cmos_frame_eop(frame_eop),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0, failures = 0;
  int   err_seen = 0, exp_err = 0, exp_fc = 0, frame_seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected pixel per valid strobe
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) err_seen++;
      if (frame_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got data=%h sop=%b eop=%b expected no pixel",
                   frame_data, frame_sop, frame_eop);
        end else begin
          e = exp_q.pop_front();
          if ({frame_data, frame_sop, frame_eop} !== e) begin
            failures++;
            $display("FAIL pixel: got data=%h sop=%b eop=%b expected data=%h sop=%b eop=%b",
                     frame_data, frame_sop, frame_eop, e.data, e.sop, e.eop);
          end
        end
      end else if (frame_sop === 1'b1 || frame_eop === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL marker_without_valid: got sop=%b eop=%b expected 0", frame_sop, frame_eop);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

  // kind: 0 none, 1 drop cap_en after act_line, 2 pulse rst after act_line
  task automatic send_frame(input int nlines, input int short_line, input int short_pix,
                            input bit cap, input int act_line, input int kind, input bit fixed);
    int          f, np;
    bit          live, eop_exp;
    logic [15:0] p;
    pix_t        e;
    f       = frame_seq++;
    live    = cap;
    eop_exp = 1'b0;
    vsync   = 1'b1;
    cyc(4);
    vsync = 1'b0;
    cyc(3);
    for (int l = 0; l < nlines; l++) begin
      np   = (l == short_line) ? short_pix : H;
      href = 1'b1;
      for (int x = 0; x < np; x++) begin
        p = fixed ? 16'hF81F : 16'(f * 4957 + l * 257 + x * 785);
        if (live && l < V && x < H) begin
`ifdef CMOS_CAP_TESTPAT_EN
          e.data = {8'(x), 8'(l), 8'(exp_fc)};
`else
          e.data = fixed ? 24'hF800F8 : expand(p);
`endif
          e.sop = (x == 0) && (l == 0);
          e.eop = (x == H - 1) && (l == V - 1);
          if (e.eop) eop_exp = 1'b1;
          exp_q.push_back(e);
        end
        data = p[15:8];
        cyc(1);
        data = p[7:0];
        cyc(1);
      end
      href = 1'b0;
      data = 8'h00;
      cyc(4);
      if (live && np != H) exp_err++;
      if (l == act_line && kind == 1) cap_en = 1'b0;
      if (l == act_line && kind == 2) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        live   = 1'b0;
        exp_fc = 0;
      end
    end
    if (live && nlines != V) exp_err++;
    vsync = 1'b1;
    cyc(5);
    if (live && eop_exp) exp_fc++;
  endtask

  task automatic end_check(input string name);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
    check({name, "_err_count"}, 32'(err_seen), 32'(exp_err));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    vsync    = 1'b1;
    href     = 1'b0;
    data     = 8'h00;
    cfg_done = 1'b0;
    cap_en   = 1'b1;
    cyc(3);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_sop", 32'(frame_sop), 32'd0);
    check("reset_eop", 32'(frame_eop), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_data", 32'(frame_data), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    cyc(3);
    cfg_done = 1'b1;
    cyc(3);

    // Two skipped frames, then one delivered frame of constant pixels
    send_frame(4, -1, 0, 1'b0, -1, 0, 1'b0);
    send_frame(4, -1, 0, 1'b0, -1, 0, 1'b0);
    send_frame(4, -1, 0, 1'b1, -1, 0, 1'b1);
    end_check("good");

    // Short last line: no eop, frame_cnt unchanged
    send_frame(4, 3, 6, 1'b1, -1, 0, 1'b0);
    end_check("short_line");

    // Long line: extra pixels dropped
    send_frame(4, 1, 10, 1'b1, -1, 0, 1'b0);
    end_check("long_line");

    // Five lines: fifth dropped, error at frame end
    send_frame(5, -1, 0, 1'b1, -1, 0, 1'b0);
    end_check("extra_line");

    // cap_en dropped mid-frame: frame completes, next is ignored, then resumes
    send_frame(4, -1, 0, 1'b1, 1, 1, 1'b0);
    send_frame(4, -1, 0, 1'b0, -1, 0, 1'b0);
    end_check("cap_off");
    cap_en = 1'b1;
    send_frame(4, -1, 0, 1'b1, -1, 0, 1'b0);
    end_check("cap_on");

    // Reset mid-frame: skip sequence repeats
    send_frame(4, -1, 0, 1'b1, 1, 2, 1'b0);
    send_frame(4, -1, 0, 1'b0, -1, 0, 1'b0);
    send_frame(4, -1, 0, 1'b0, -1, 0, 1'b0);
    send_frame(4, -1, 0, 1'b1, -1, 0, 1'b0);
    end_check("after_rst");

    cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
